// File: rtl/debug_mon_pkg.sv
// Shared types for the debug monitor memory access block: FSM states, jdo field
// positions and the strobe priority decode.
package debug_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ
    } mon_state_t;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_LOAD,
        CMD_WRITE,
        CMD_INCR
    } mon_cmd_t;

    localparam int JDO_ADDR_LSB = 26;
    localparam int JDO_RD_BIT   = 25;
    localparam int JDO_CLR_BIT  = 24;
    localparam int JDO_DATA_LSB = 3;

    // Address load beats write beats increment-and-read.
    function automatic mon_cmd_t pick_cmd(input logic act_a, input logic act_b, input logic noact_a);
        if (act_a)        return CMD_LOAD;
        else if (act_b)   return CMD_WRITE;
        else if (noact_a) return CMD_INCR;
        else              return CMD_NONE;
    endfunction

    // True when more than one strobe is present, i.e. something gets dropped.
    function automatic logic strobes_collide(input logic act_a, input logic act_b, input logic noact_a);
        return (act_a & act_b) | (act_a & noact_a) | (act_b & noact_a);
    endfunction

endpackage

// File: rtl/debug_mon_grant_timer.sv
// Grant wait counter: cleared by load, advances on count, flags expiry on the
// TIMEOUT-th ungranted cycle of a request.
module debug_mon_grant_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic count,
    output logic expired
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset_n)
            cnt <= '0;
        else if (load)
            cnt <= '0;
        else if (count && !expired)
            cnt <= cnt + 1'b1;
    end

    assign expired = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/system_worker_3_cpu_cpu_debug_mon_access.sv
// Turns JTAG monitor strobes into single reads/writes on the debug memory port
// and reports MonDReg, monitor_ready and a sticky monitor_error back.
module system_worker_3_cpu_cpu_debug_mon_access
    import debug_mon_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] MonAReg,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    mon_state_t        state, state_nxt;
    logic [ADDR_W-1:0] areg_nxt;
    logic [31:0]       dreg_nxt;
    logic              err_nxt;
    logic              in_req;
    logic              expired;
    logic              any_strobe;
    logic              unused_jdo_bits;

    assign unused_jdo_bits = ^jdo;
    assign any_strobe      = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign in_req          = (state == ST_RD_REQ) || (state == ST_WR_REQ);

    debug_mon_grant_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (!in_req),
        .count   (in_req && !mem_gnt),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            MonAReg       <= '0;
            MonDReg       <= '0;
            monitor_error <= 1'b0;
        end else begin
            state         <= state_nxt;
            MonAReg       <= areg_nxt;
            MonDReg       <= dreg_nxt;
            monitor_error <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        areg_nxt  = MonAReg;
        dreg_nxt  = MonDReg;
        err_nxt   = monitor_error;
        case (state)
            ST_IDLE: begin
                case (pick_cmd(take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a))
                    CMD_LOAD: begin
                        areg_nxt = jdo[JDO_ADDR_LSB +: ADDR_W];
                        if (jdo[JDO_CLR_BIT])
                            err_nxt = 1'b0;
                        if (jdo[JDO_RD_BIT])
                            state_nxt = ST_RD_REQ;
                    end
                    CMD_WRITE: begin
                        dreg_nxt  = jdo[JDO_DATA_LSB +: 32];
                        state_nxt = ST_WR_REQ;
                    end
                    CMD_INCR: begin
                        areg_nxt  = MonAReg + 1'b1;
                        state_nxt = ST_RD_REQ;
                    end
                    default: ;
                endcase
                // A dropped strobe flags even if the winning load cleared the error.
                if (strobes_collide(take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a))
                    err_nxt = 1'b1;
            end
            ST_RD_REQ: begin
                if (mem_gnt) begin
                    state_nxt = ST_RD_WAIT;
                end else if (expired) begin
                    state_nxt = ST_IDLE;
                    err_nxt   = 1'b1;
                end
            end
            ST_RD_WAIT: begin
                dreg_nxt  = mem_rdata;
                state_nxt = ST_IDLE;
            end
            ST_WR_REQ: begin
                if (mem_gnt) begin
                    areg_nxt  = MonAReg + 1'b1;
                    state_nxt = ST_IDLE;
                end else if (expired) begin
                    state_nxt = ST_IDLE;
                    err_nxt   = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (state != ST_IDLE && any_strobe)
            err_nxt = 1'b1;
    end

    assign mem_re        = (state == ST_RD_REQ);
    assign mem_we        = (state == ST_WR_REQ);
    assign monitor_ready = (state == ST_IDLE);
    assign mem_addr      = MonAReg;
    assign mem_wdata     = MonDReg;

endmodule

// File: tb/tb_system_worker_3_cpu_cpu_debug_mon_access.sv
// Directed bench with a memory/arbiter model and a read-data scoreboard queue.
module tb_system_worker_3_cpu_cpu_debug_mon_access;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
    logic [7:0]  mem_addr, MonAReg;
    logic        mem_re, mem_we, mem_gnt;
    logic [31:0] mem_wdata, mem_rdata, MonDReg;
    logic        monitor_ready, monitor_error;

    int passed = 0;
    int total  = 0;

    logic [31:0] mem [0:255];
    logic [31:0] exp_q [$];
    logic [31:0] last_d;
    int          gnt_delay = 0;
    int          wait_cnt = 0, run_len = 0, last_req_len = 0;
    logic        rd_pending = 1'b0;
    logic [7:0]  rd_addr;
    logic        chk_en = 1'b0;

    system_worker_3_cpu_cpu_debug_mon_access dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .mem_addr                (mem_addr),
        .mem_re                  (mem_re),
        .mem_we                  (mem_we),
        .mem_wdata               (mem_wdata),
        .mem_gnt                 (mem_gnt),
        .mem_rdata               (mem_rdata),
        .MonAReg                 (MonAReg),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Arbiter/memory model: runs 1 time unit after each edge, ahead of the main sequence.
    initial begin
        mem_gnt   = 1'b0;
        mem_rdata = 32'hBAD0BAD0;
        forever begin
            @(posedge clk);
            #1;
            mem_rdata  = rd_pending ? mem[rd_addr] : 32'hBAD0BAD0;
            rd_pending = 1'b0;
            if (chk_en && reset_n) begin
                total++;
                assert (!(mem_re === 1'b1 && mem_we === 1'b1)) passed++;
                else $error("FAIL re_we_excl: re=%b we=%b expected not both high", mem_re, mem_we);
            end
            if (mem_re === 1'b1 || mem_we === 1'b1) begin
                run_len++;
                mem_gnt = (gnt_delay >= 0 && wait_cnt == gnt_delay);
                wait_cnt++;
                if (mem_gnt && mem_re) begin
                    rd_pending = 1'b1;
                    rd_addr    = mem_addr;
                end
                if (mem_gnt && mem_we)
                    mem[mem_addr] = mem_wdata;
            end else begin
                if (run_len != 0)
                    last_req_len = run_len;
                run_len  = 0;
                wait_cnt = 0;
                mem_gnt  = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_strobes();
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        jdo                     = '0;
    endtask

    task automatic strobe(input logic a, input logic b, input logic n,
                          input logic [7:0] addr, input logic rd, input logic clr);
        logic [37:0] j;
        j = '0;
        j[26 +: 8] = addr;
        j[25]      = rd;
        j[24]      = clr;
        jdo                     = j;
        take_action_ocimem_a    = a;
        take_action_ocimem_b    = b;
        take_no_action_ocimem_a = n;
        tick();
        clear_strobes();
    endtask

    task automatic strobe_write(input logic [31:0] data);
        logic [37:0] j;
        j = '0;
        j[34:3] = data;
        jdo                  = j;
        take_action_ocimem_b = 1'b1;
        tick();
        clear_strobes();
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int n;
        n = 0;
        while (monitor_ready !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(tag, monitor_ready, 1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            mem[i] = 32'hA5000000 | i;
        mem[8'h10] = 32'hDEADBEEF;
        clear_strobes();
        reset_n = 1'b0;
        tick();
        tick();
        check("rst_ready", monitor_ready, 1);
        check("rst_error", monitor_error, 0);
        check("rst_areg", MonAReg, 0);
        check("rst_dreg", MonDReg, 0);
        check("rst_re", mem_re, 0);
        check("rst_we", mem_we, 0);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        tick();

        // Address load with read, immediate grant
        gnt_delay = 0;
        exp_q.push_back(mem[8'h10]);
        strobe(1, 0, 0, 8'h10, 1, 0);
        check("rd1_re", mem_re, 1);
        check("rd1_addr", mem_addr, 8'h10);
        check("rd1_ready_low", monitor_ready, 0);
        tick();
        check("rd1_wait_ready", monitor_ready, 0);
        tick();
        check("rd1_ready", monitor_ready, 1);
        last_d = exp_q.pop_front();
        check("rd1_dreg", MonDReg, last_d);

        // Write at 0xFF with 3-cycle grant delay, address wraps
        strobe(1, 0, 0, 8'hFF, 0, 0);
        check("wr_areg_load", MonAReg, 8'hFF);
        check("wr_load_ready", monitor_ready, 1);
        gnt_delay = 3;
        strobe_write(32'h12345678);
        check("wr_we", mem_we, 1);
        check("wr_wdata", mem_wdata, 32'h12345678);
        wait_ready("wr_done", 20);
        check("wr_len", last_req_len, 4);
        check("wr_mem", mem[8'hFF], 32'h12345678);
        check("wr_wrap", MonAReg, 8'h00);
        check("wr_err", monitor_error, 0);
        last_d = 32'h12345678;

        // Auto-increment reads from 0x20
        strobe(1, 0, 0, 8'h20, 0, 0);
        gnt_delay = 1;
        for (int i = 1; i <= 3; i++) begin
            exp_q.push_back(mem[8'h20 + i]);
            strobe(0, 0, 1, 8'h00, 0, 0);
            check("inc_addr", mem_addr, 8'h20 + i);
            check("inc_re", mem_re, 1);
            wait_ready("inc_done", 20);
            last_d = exp_q.pop_front();
            check("inc_dreg", MonDReg, last_d);
        end

        // Simultaneous strobes: load wins, error set, clear later
        strobe(1, 1, 0, 8'h40, 0, 0);
        check("sim_areg", MonAReg, 8'h40);
        check("sim_err", monitor_error, 1);
        check("sim_no_write", mem_we, 0);
        check("sim_dreg", MonDReg, last_d);
        strobe(1, 0, 0, 8'h41, 0, 1);
        check("clr_err", monitor_error, 0);
        check("clr_areg", MonAReg, 8'h41);

        // Strobe while busy is ignored and flags an error
        gnt_delay = 5;
        exp_q.push_back(mem[8'h42]);
        strobe(0, 0, 1, 8'h00, 0, 0);
        strobe_write(32'hFFFFFFFF);
        check("busy_err", monitor_error, 1);
        wait_ready("busy_done", 20);
        last_d = exp_q.pop_front();
        check("busy_dreg", MonDReg, last_d);

        // Grant timeout: no grant at all
        strobe(1, 0, 0, 8'h50, 0, 1);
        check("to_clr", monitor_error, 0);
        gnt_delay = -1;
        strobe(1, 0, 0, 8'h50, 1, 0);
        wait_ready("to_done", 40);
        check("to_len", last_req_len, 15);
        check("to_err", monitor_error, 1);
        check("to_dreg", MonDReg, last_d);
        check("to_areg", MonAReg, 8'h50);
        check("to_re", mem_re, 0);

        // Grant on exactly the 15th cycle wins
        strobe(1, 0, 0, 8'h50, 0, 1);
        gnt_delay = 14;
        exp_q.push_back(mem[8'h50]);
        strobe(1, 0, 0, 8'h50, 1, 0);
        wait_ready("late_done", 40);
        check("late_len", last_req_len, 15);
        check("late_err", monitor_error, 0);
        last_d = exp_q.pop_front();
        check("late_dreg", MonDReg, last_d);

        // Reset mid-write, with the error flag set beforehand
        gnt_delay = -1;
        strobe_write(32'hCAFEF00D);
        check("mid_we", mem_we, 1);
        strobe(1, 0, 0, 8'h77, 0, 0);
        check("mid_err", monitor_error, 1);
        reset_n = 1'b0;
        tick();
        check("mid_rst_we", mem_we, 0);
        check("mid_rst_re", mem_re, 0);
        check("mid_rst_ready", monitor_ready, 1);
        check("mid_rst_err", monitor_error, 0);
        check("mid_rst_areg", MonAReg, 0);
        check("mid_rst_dreg", MonDReg, 0);
        reset_n = 1'b1;
        tick();
        check("post_rst_ready", monitor_ready, 1);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
